// File: rtl/crop_window_ctrl_if.sv
// rtl/crop_window_ctrl_if.sv - AXI-Stream video input bundle for crop_window_ctrl
interface crop_window_ctrl_if #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32
) ();
  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA;
  logic                            S_AXIS_TVALID;
  logic                            S_AXIS_TREADY;
  logic                            S_AXIS_TLAST;
  logic                            S_AXIS_TUSER;

  modport master (
    output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TUSER,
    input  S_AXIS_TREADY
  );

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TUSER,
    output S_AXIS_TREADY
  );
endinterface

// File: rtl/crop_window_ctrl.sv
// rtl/crop_window_ctrl.sv - crops a video stream into the output FIFO write port
// Tracks column/row of every accepted beat and forwards only pixels inside the window.
module crop_window_ctrl #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_DIM_WIDTH          = 12
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESETN,
  crop_window_ctrl_if.slave               s_axis,
  input  logic                            cfg_enable,
  input  logic [C_DIM_WIDTH-1:0]          cfg_in_width,
  input  logic [C_DIM_WIDTH-1:0]          cfg_x0,
  input  logic [C_DIM_WIDTH-1:0]          cfg_y0,
  input  logic [C_DIM_WIDTH-1:0]          cfg_width,
  input  logic [C_DIM_WIDTH-1:0]          cfg_height,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] fifo_data,
  output logic                            fifo_last,
  output logic                            fifo_user,
  output logic                            frame_done,
  output logic                            cfg_err,
  output logic                            line_err,
  output logic                            busy
);
  localparam int DW = C_DIM_WIDTH;
  localparam logic [DW-1:0] ONE   = 1;
  localparam logic [DW:0]   ONE_X = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] x_q, x_d, y_q, y_d;
  logic [DW-1:0] in_w_q, in_w_d, x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic          frame_done_q, frame_done_d, cfg_err_q, cfg_err_d, line_err_q, line_err_d;

  logic          beat, sof, cfg_ok, start_ok, framed, in_win, wr, frame_end, line_end, bad_line;
  logic [DW:0]   cfg_xend, x_end, y_end;
  logic [DW-1:0] ex, ey, e_in_w, e_x0, e_y0, e_w, e_h, last_col;

  assign s_axis.S_AXIS_TREADY = S_AXIS_ARESETN && !fifo_full;
  assign beat     = s_axis.S_AXIS_TVALID && s_axis.S_AXIS_TREADY;
  assign sof      = beat && s_axis.S_AXIS_TUSER;
  assign cfg_xend = {1'b0, cfg_x0} + {1'b0, cfg_width};
  assign cfg_ok   = (cfg_width != '0) && (cfg_height != '0) && (cfg_in_width != '0) &&
                    (cfg_xend <= {1'b0, cfg_in_width});
  assign start_ok = cfg_enable && cfg_ok;

  always_comb begin
    // An SOF beat is pixel (0,0) judged against the config arriving with it
    ex        = sof ? '0 : x_q;
    ey        = sof ? '0 : y_q;
    e_in_w    = sof ? cfg_in_width : in_w_q;
    e_x0      = sof ? cfg_x0 : x0_q;
    e_y0      = sof ? cfg_y0 : y0_q;
    e_w       = sof ? cfg_width : w_q;
    e_h       = sof ? cfg_height : h_q;
    x_end     = {1'b0, e_x0} + {1'b0, e_w};
    y_end     = {1'b0, e_y0} + {1'b0, e_h};
    last_col  = e_in_w - ONE;
    framed    = sof ? start_ok : (state_q != ST_IDLE);
    in_win    = (ex >= e_x0) && ({1'b0, ex} < x_end) && (ey >= e_y0) && ({1'b0, ey} < y_end);
    wr        = beat && in_win && (sof ? start_ok : (state_q == ST_ACTIVE));
    frame_end = wr && ({1'b0, ex} == x_end - ONE_X) && ({1'b0, ey} == y_end - ONE_X);
    line_end  = s_axis.S_AXIS_TLAST || (ex == last_col);
    bad_line  = (s_axis.S_AXIS_TLAST && (ex < last_col)) ||
                (!s_axis.S_AXIS_TLAST && (ex == last_col));
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    in_w_d       = in_w_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    w_d          = w_q;
    h_d          = h_q;
    frame_done_d = frame_end;
    cfg_err_d    = 1'b0;
    line_err_d   = 1'b0;
    if (beat) begin
      if (line_end) begin
        x_d = '0;
        y_d = (ey == '1) ? ey : ey + ONE;
      end else begin
        x_d = ex + ONE;
        y_d = ey;
      end
      line_err_d = framed && bad_line;
    end
    if (sof) begin
      in_w_d    = cfg_in_width;
      x0_d      = cfg_x0;
      y0_d      = cfg_y0;
      w_d       = cfg_width;
      h_d       = cfg_height;
      cfg_err_d = cfg_enable && !cfg_ok;
      if ((state_q == ST_ACTIVE) && ((x_q != '0) || (y_q != '0))) begin
        line_err_d = 1'b1;
      end
      if (!start_ok) begin
        state_d = ST_IDLE;
      end else if (frame_end) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_ACTIVE;
      end
    end else if ((state_q == ST_ACTIVE) && frame_end) begin
      state_d = ST_DRAIN;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      in_w_q       <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      in_w_q       <= in_w_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      w_q          <= w_d;
      h_q          <= h_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
      line_err_q   <= line_err_d;
    end
  end

  assign fifo_wr_en = wr;
  assign fifo_data  = s_axis.S_AXIS_TDATA;
  assign fifo_user  = wr && (ex == e_x0) && (ey == e_y0);
  assign fifo_last  = wr && ({1'b0, ex} == x_end - ONE_X);
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;
  assign line_err   = line_err_q;
  assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_crop_window_ctrl.sv
// tb/tb_crop_window_ctrl.sv - self-checking bench for crop_window_ctrl
module tb_crop_window_ctrl;
  localparam int DWD = 32;
  localparam int DIM = 12;

  typedef struct packed { logic [31:0] data; logic user; logic last; } beat_t;
  typedef struct {
    int in_w; int lines; int x0; int y0; int w; int h; bit en;
    int n_wr; int sum; int n_user; int n_last; int cfg_e; int done; int busy;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crop_window_ctrl_if #(.C_S_AXIS_TDATA_WIDTH(DWD)) s_axis ();
  logic           cfg_enable;
  logic [DIM-1:0] cfg_in_width, cfg_x0, cfg_y0, cfg_width, cfg_height;
  logic           fifo_full, fifo_wr_en, fifo_last, fifo_user, frame_done, cfg_err, line_err, busy;
  logic [DWD-1:0] fifo_data;

  crop_window_ctrl #(.C_S_AXIS_TDATA_WIDTH(DWD), .C_DIM_WIDTH(DIM)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .s_axis(s_axis),
    .cfg_enable(cfg_enable), .cfg_in_width(cfg_in_width), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .fifo_last(fifo_last), .fifo_user(fifo_user),
    .frame_done(frame_done), .cfg_err(cfg_err), .line_err(line_err), .busy(busy)
  );

  int    cyc = 0, n_done = 0, n_cfg_err = 0, n_line_err = 0, n_full_cyc = 0, n_full_bad = 0;
  int    last_wr_cyc = 0, done_cyc = 0;
  beat_t got[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fifo_wr_en) begin
      got.push_back({fifo_data, fifo_user, fifo_last});
      last_wr_cyc <= cyc;
    end
    if (frame_done) begin
      n_done <= n_done + 1;
      done_cyc <= cyc;
    end
    if (cfg_err) n_cfg_err <= n_cfg_err + 1;
    if (line_err) n_line_err <= n_line_err + 1;
    if (fifo_full) begin
      n_full_cyc <= n_full_cyc + 1;
      if (s_axis.S_AXIS_TREADY || fifo_wr_en) n_full_bad <= n_full_bad + 1;
    end
  end

  int    n_cmp, n_fail, full_hold;
  beat_t stim[$];
  beat_t expq[$];
  row_t  rows[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input bit en, input int iw, input int x0, input int y0, input int w, input int h);
    cfg_enable   = en;
    cfg_in_width = DIM'(iw);
    cfg_x0       = DIM'(x0);
    cfg_y0       = DIM'(y0);
    cfg_width    = DIM'(w);
    cfg_height   = DIM'(h);
  endtask

  // Reference: a beat is written iff its (x,y) lies in the window; user at origin, last at right edge
  task automatic build_frame(input int iw, input int lines, input bit mk_exp,
                             input int trunc_line, input int trunc_len, input int stop_after);
    int n, len, x0, y0, w, h;
    beat_t b, e;
    n = 0;
    x0 = int'(cfg_x0); y0 = int'(cfg_y0); w = int'(cfg_width); h = int'(cfg_height);
    for (int y = 0; y < lines; y++) begin
      len = (y == trunc_line) ? trunc_len : iw;
      for (int x = 0; x < len; x++) begin
        if (stop_after >= 0 && n >= stop_after) return;
        b.data = 32'(y * iw + x);
        b.user = (x == 0 && y == 0);
        b.last = (x == len - 1);
        stim.push_back(b);
        if (mk_exp && x >= x0 && x < x0 + w && y >= y0 && y < y0 + h) begin
          e.data = b.data;
          e.user = (x == x0 && y == y0);
          e.last = (x == x0 + w - 1);
          expq.push_back(e);
        end
        n++;
      end
    end
  endtask

  task automatic step_full(input bit rnd);
    if (full_hold > 0) full_hold--;
    fifo_full = (full_hold > 0) || (rnd && $urandom_range(0, 3) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      step_full(1'b0);
    end
  endtask

  task automatic drive(input int stall_at, input bit rnd);
    int idx;
    bit acc;
    beat_t b;
    idx = 0;
    while (stim.size() > 0) begin
      b = stim.pop_front();
      if (idx == stall_at) begin
        full_hold = 5;
        fifo_full = 1'b1;
      end
      s_axis.S_AXIS_TVALID = 1'b1;
      s_axis.S_AXIS_TDATA  = b.data;
      s_axis.S_AXIS_TUSER  = b.user;
      s_axis.S_AXIS_TLAST  = b.last;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        acc = s_axis.S_AXIS_TREADY;
        @(posedge clk); #1;
        step_full(rnd);
      end
      if (!acc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL beat_accept: beat %0d got not-accepted expected accepted", idx);
      end
      s_axis.S_AXIS_TVALID = 1'b0;
      if (rnd && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk); #1;
          step_full(rnd);
        end
      end
      idx++;
    end
  endtask

  task automatic cmp_writes(input string nm, input int base);
    check({nm, " count"}, 64'(got.size() - base), 64'(expq.size()));
    for (int i = 0; i < expq.size() && base + i < got.size(); i++)
      check($sformatf("%s wr%0d", nm, i), {30'b0, got[base + i]}, {30'b0, expq[i]});
    expq.delete();
  endtask

  initial begin
    int base, s_done, s_ce, s_le, s_full, s_bad, sum, nu, nl;
    int iw, ln, w, x0, h, y0, mode;
    bit en, valid;
    n_cmp = 0; n_fail = 0; full_hold = 0;
    s_axis.S_AXIS_TVALID = 1'b1;
    s_axis.S_AXIS_TDATA  = '0;
    s_axis.S_AXIS_TUSER  = 1'b1;
    s_axis.S_AXIS_TLAST  = 1'b0;
    fifo_full = 1'b0;
    set_cfg(1'b1, 8, 2, 1, 3, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tready", 64'(s_axis.S_AXIS_TREADY), 0);
    check("reset wr_en", 64'(fifo_wr_en), 0);
    check("reset busy", 64'(busy), 0);
    check("reset frame_done", 64'(frame_done), 0);
    check("reset cfg_err", 64'(cfg_err), 0);
    check("reset line_err", 64'(line_err), 0);
    s_axis.S_AXIS_TVALID = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    rows[0] = row_t'{8, 6, 2, 1, 3, 2, 1'b1, 6, 90, 1, 2, 0, 1, 1};
    rows[1] = row_t'{8, 6, 6, 0, 3, 1, 1'b1, 0, 0, 0, 0, 1, 0, 0};
    rows[2] = row_t'{8, 2, 7, 1, 1, 1, 1'b1, 1, 15, 1, 1, 0, 1, 1};
    rows[3] = row_t'{8, 2, 0, 0, 2, 1, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    rows[4] = row_t'{4, 3, 0, 0, 4, 3, 1'b1, 12, 66, 1, 3, 0, 1, 1};
    rows[5] = row_t'{4, 2, 0, 0, 0, 1, 1'b1, 0, 0, 0, 0, 1, 0, 0};
    rows[6] = row_t'{5, 3, 3, 2, 2, 1, 1'b1, 2, 27, 1, 1, 0, 1, 1};
    rows[7] = row_t'{3, 1, 0, 0, 1, 1, 1'b1, 1, 0, 1, 1, 0, 1, 1};

    for (int r = 0; r < 8; r++) begin
      set_cfg(rows[r].en, rows[r].in_w, rows[r].x0, rows[r].y0, rows[r].w, rows[r].h);
      base = got.size(); s_done = n_done; s_ce = n_cfg_err; s_le = n_line_err;
      build_frame(rows[r].in_w, rows[r].lines, r == 0, -1, 0, -1);
      drive(-1, 1'b0);
      idle(3);
      sum = 0; nu = 0; nl = 0;
      for (int i = base; i < got.size(); i++) begin
        sum += int'(got[i].data);
        nu  += int'(got[i].user);
        nl  += int'(got[i].last);
      end
      check($sformatf("row%0d writes", r), 64'(got.size() - base), 64'(rows[r].n_wr));
      check($sformatf("row%0d sum", r), 64'(sum), 64'(rows[r].sum));
      check($sformatf("row%0d users", r), 64'(nu), 64'(rows[r].n_user));
      check($sformatf("row%0d lasts", r), 64'(nl), 64'(rows[r].n_last));
      check($sformatf("row%0d cfg_err", r), 64'(n_cfg_err - s_ce), 64'(rows[r].cfg_e));
      check($sformatf("row%0d done", r), 64'(n_done - s_done), 64'(rows[r].done));
      check($sformatf("row%0d line_err", r), 64'(n_line_err - s_le), 0);
      check($sformatf("row%0d busy", r), 64'(busy), 64'(rows[r].busy));
      if (r == 0) begin
        check("done latency", 64'(done_cyc - last_wr_cyc), 1);
        cmp_writes("basic", base);
      end
    end

    // FIFO full held for five cycles mid-line
    set_cfg(1'b1, 8, 2, 1, 3, 2);
    base = got.size(); s_full = n_full_cyc; s_bad = n_full_bad;
    build_frame(8, 6, 1'b1, -1, 0, -1);
    drive(11, 1'b0);
    idle(3);
    check("stall cycles", 64'(n_full_cyc - s_full), 5);
    check("stall ready/write", 64'(n_full_bad - s_bad), 0);
    cmp_writes("stall", base);

    // SOF injected at (4,2)
    base = got.size(); s_done = n_done; s_le = n_line_err;
    build_frame(8, 6, 1'b1, -1, 0, 20);
    build_frame(8, 6, 1'b1, -1, 0, -1);
    drive(-1, 1'b0);
    idle(3);
    check("sof inject line_err", 64'(n_line_err - s_le), 1);
    check("sof inject done", 64'(n_done - s_done), 1);
    cmp_writes("sof inject", base);

    // Early TLAST at x=5 on line 0
    base = got.size(); s_done = n_done; s_le = n_line_err;
    build_frame(8, 6, 1'b1, 0, 6, -1);
    drive(-1, 1'b0);
    idle(3);
    check("early tlast line_err", 64'(n_line_err - s_le), 1);
    check("early tlast done", 64'(n_done - s_done), 1);
    cmp_writes("early tlast", base);

    // Reset during a write on line 1
    build_frame(8, 6, 1'b0, -1, 0, 11);
    drive(-1, 1'b0);
    s_axis.S_AXIS_TVALID = 1'b1;
    s_axis.S_AXIS_TDATA  = 32'd11;
    s_axis.S_AXIS_TUSER  = 1'b0;
    s_axis.S_AXIS_TLAST  = 1'b0;
    @(negedge clk);
    check("pre-reset wr_en", 64'(fifo_wr_en), 1);
    rst_n = 1'b0;
    #1;
    check("mid reset tready", 64'(s_axis.S_AXIS_TREADY), 0);
    check("mid reset wr_en", 64'(fifo_wr_en), 0);
    check("mid reset busy", 64'(busy), 0);
    s_axis.S_AXIS_TVALID = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = got.size(); s_done = n_done; s_le = n_line_err;
    build_frame(8, 6, 1'b1, -1, 0, -1);
    drive(-1, 1'b0);
    idle(3);
    check("post reset done", 64'(n_done - s_done), 1);
    check("post reset line_err", 64'(n_line_err - s_le), 0);
    cmp_writes("post reset", base);

    // Randomized frames with random backpressure and gaps
    for (int k = 0; k < 25; k++) begin
      iw = $urandom_range(1, 10);
      ln = $urandom_range(1, 6);
      w  = $urandom_range(1, iw);
      x0 = $urandom_range(0, iw - w);
      h  = $urandom_range(1, ln);
      y0 = $urandom_range(0, ln - h);
      mode = $urandom_range(0, 5);
      en = (mode != 1);
      valid = 1'b1;
      if (mode == 0) begin
        w = iw - x0 + 1;
        valid = 1'b0;
      end
      set_cfg(en, iw, x0, y0, w, h);
      base = got.size(); s_done = n_done; s_ce = n_cfg_err; s_le = n_line_err;
      build_frame(iw, ln, en && valid, -1, 0, -1);
      drive(-1, 1'b1);
      idle(3);
      cmp_writes($sformatf("rand%0d", k), base);
      check($sformatf("rand%0d done", k), 64'(n_done - s_done), 64'(en && valid));
      check($sformatf("rand%0d cfg_err", k), 64'(n_cfg_err - s_ce), 64'(en && !valid));
      check($sformatf("rand%0d line_err", k), 64'(n_line_err - s_le), 0);
      check($sformatf("rand%0d busy", k), 64'(busy), 64'(en && valid));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/crop_window_ctrl.md
# crop_window_ctrl

Write-side sequencer for the AXI-Stream output FIFO. It accepts a raw video stream on an AXI-Stream slave port and tracks pixel column and row. It forwards only pixels inside a configured crop rectangle into the FIFO write port, regenerating start-of-frame (user) and end-of-line (last) markers for the cropped image. It sits between the video input and the output FIFO, and throttles the input with the FIFO full flag.

## Interface
- C_S_AXIS_TDATA_WIDTH, 32: pixel width, equal to the FIFO data width.
- C_DIM_WIDTH, 12: width of all coordinate, dimension and counter fields.

- S_AXIS_ACLK  in  1  sole clock, rising edge.
- S_AXIS_ARESETN  in  1  asynchronous, active-low reset.
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  input pixel.
- S_AXIS_TVALID  in  1  input beat valid.
- S_AXIS_TREADY  out  1  input beat accepted when TVALID&&TREADY.
- S_AXIS_TLAST  in  1  end of input line.
- S_AXIS_TUSER  in  1  start of input frame (first pixel).
- cfg_enable  in  1  cropping enabled; sampled at SOF.
- cfg_in_width  in  C_DIM_WIDTH  input line length in pixels.
- cfg_x0, cfg_y0  in  C_DIM_WIDTH  crop origin (column, row).
- cfg_width, cfg_height  in  C_DIM_WIDTH  crop size.
- fifo_full  in  1  FIFO cannot accept a write.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_data  out  C_S_AXIS_TDATA_WIDTH  write data (= S_AXIS_TDATA).
- fifo_last  out  1  last pixel of a cropped line.
- fifo_user  out  1  first pixel of a cropped frame.
- frame_done  out  1  one-cycle pulse after the last crop pixel is written.
- cfg_err  out  1  one-cycle pulse: invalid config at SOF.
- line_err  out  1  one-cycle pulse: malformed line or unexpected SOF.
- busy  out  1  state != IDLE.

## Operation
- Beat = accepted handshake. S_AXIS_TREADY = !fifo_full in all states. Every accepted beat advances the counters. Pixels outside the window are consumed and dropped.
- Config is latched into shadow registers on each SOF beat (TUSER=1). It is valid iff cfg_width>0, cfg_height>0, cfg_x0+cfg_width <= cfg_in_width, and cfg_in_width>0. The sum is computed at C_DIM_WIDTH+1 bits.
- Counters x and y. An SOF beat is pixel (0,0). After a beat: if TLAST or x==in_width-1, then x<=0 and y<=y+1, with y saturating at all-ones. Otherwise x<=x+1.
- in_window = x0 <= x < x0+w and y0 <= y < y0+h, using latched values.
- fifo_wr_en = beat && state==ACTIVE && in_window. The path is combinational with zero latency. fifo_user = wr_en && x==x0 && y==y0. fifo_last = wr_en && x==x0+w-1.
- FSM states: IDLE, ACTIVE, DRAIN.
  - IDLE: wait for an SOF beat. With cfg_enable=1 and a valid config, go to ACTIVE; that beat is evaluated as (0,0). With an invalid config, cfg_err pulses and the block stays IDLE. With cfg_enable=0, stay IDLE. Non-SOF beats are dropped.
  - ACTIVE: on the beat at (x0+w-1, y0+h-1), write it and go to DRAIN.
  - DRAIN: drop beats until the next SOF, then re-evaluate exactly as in IDLE.
  - An SOF beat in ACTIVE when (x,y)!=(0,0): line_err pulses and the frame restarts as in IDLE.
- line_err also pulses on early TLAST (x<in_width-1) or a missing TLAST at x==in_width-1. Both end the line.

## Timing
- Reset (async assert, sync deassert externally): state=IDLE, x=y=0, shadow config=0, busy=0, frame_done=cfg_err=line_err=0, S_AXIS_TREADY=0 while reset is asserted.
- fifo_wr_en, fifo_data, fifo_last and fifo_user are combinational from the current beat and registered state. A write happens in the same cycle as the accepted beat. fifo_full=1 blocks acceptance, so no beat is written while full.
- frame_done, cfg_err and line_err are registered and assert the cycle after the causing beat, for 1 cycle.
- Reset mid-frame discards all progress. The next frame needs a fresh SOF.
- A single-pixel window (w=h=1) asserts fifo_user, fifo_last and the transition to DRAIN on the same beat.

## Test plan
- Stream in_width=8 with 6 lines, pixel value y*8+x, crop x0=2, y0=1, w=3, h=2. Required: exactly 6 writes: 10,11,12,18,19,20. fifo_user on 10 only, fifo_last on 12 and 20, frame_done the cycle after 20, DRAIN until the next SOF.
- Same stream with fifo_full held 1 for 5 cycles mid-line. Required: TREADY=0 for those cycles, no writes, and the output sequence unchanged.
- Config x0=6, w=3, in_width=8. Required: cfg_err pulse after SOF, zero writes, state IDLE.
- SOF injected at (4,2) of the first test's frame. Required: line_err pulse and counters restart. The new frame yields the full 6-pixel crop.
- Line 0 ends with TLAST at x=5 (in_width=8). Required: line_err pulse, next beat counted as (0,1), crop output correct.
- Reset asserted during a write in line 1, then released, then a new frame sent. Required: outputs at reset values immediately, and the new frame crops correctly from its SOF.
